cell_exhaustive_checker: RTL and testbench

Synthesizable self-test engine for standard cells. It is the on-chip counterpart of a cell testbench. It drives every input pattern of a combinational cell under test and compares the cell outputs against an expected truth table supplied as a parameter. It records pass/fail, the first failing pattern, and a mismatch count, and sits beside the stdcell library as a silicon-level check of cells such as INVX1 and NAND2X1.

---
 rtl/cell_exhaustive_checker.sv | 138 +++++++++++++
 tb/tb_cell_exhaustive_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cell_exhaustive_checker.sv
// cell_exhaustive_checker
//
// On-chip exhaustive self-test for a combinational standard cell. It walks
// every input pattern of the cell under test. Each pattern is held for
// SETTLE+1 cycles, and the cell outputs are compared with an expected truth
// table on the last cycle of that window. The checker records pass/fail,
// the first failing pattern with the output seen there, and a saturating
// mismatch count.
//
// Parameters:
//   NIN    - cell input count (1..8)
//   NOUT   - cell output count (1..4)
//   TRUTH  - expected outputs; pattern p expects TRUTH[p*NOUT +: NOUT]
//   SETTLE - extra hold cycles per pattern before sampling (0..15)
//
// Ports:
//   clk          - clock, rising edge
//   reset_n      - asynchronous active-low reset
//   start        - begin a run (accepted in IDLE or DONE only)
//   dut_in       - registered pattern driven to the cell inputs
//   dut_out      - cell outputs, sampled synchronously
//   busy         - run in progress
//   done         - run finished; held until next accepted start or reset
//   pass         - valid with done; 1 when no mismatches were seen
//   fail_pattern - pattern of the first mismatch
//   fail_actual  - dut_out captured at the first mismatch
//   err_count    - mismatch count, saturating at 255
module cell_exhaustive_checker #(
    parameter int                          NIN    = 1,
    parameter int                          NOUT   = 1,
    parameter logic [NOUT*(2**NIN)-1:0]    TRUTH  = 2'b01,
    parameter int                          SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [NIN-1:0]  dut_in,
    input  logic [NOUT-1:0] dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [NIN-1:0]  fail_pattern,
    output logic [NOUT-1:0] fail_actual,
    output logic [7:0]      err_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [NIN:0] PAT_ONE = (NIN+1)'(1);

    logic [1:0]      state;
    // One extra bit so the step past the last pattern shows up as a carry.
    logic [NIN:0]    pat;
    logic [3:0]      wcnt;
    logic            first_fail;

    logic [NOUT-1:0] expected;
    logic            mismatch;
    logic [NIN:0]    pat_nxt;
    logic [7:0]      err_nxt;

    assign expected = TRUTH[pat[NIN-1:0]*NOUT +: NOUT];
    // Case inequality so X/Z on the cell outputs count as failures in simulation.
    assign mismatch = (dut_out !== expected);
    assign pat_nxt  = pat + PAT_ONE;
    assign err_nxt  = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pat          <= '0;
            wcnt         <= '0;
            first_fail   <= 1'b0;
            dut_in       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_pattern <= '0;
            fail_actual  <= '0;
            err_count    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start || (state == ST_IDLE)) begin
                        // Fresh run (or idle housekeeping): wipe all results.
                        pat          <= '0;
                        wcnt         <= '0;
                        first_fail   <= 1'b0;
                        dut_in       <= '0;
                        fail_pattern <= '0;
                        fail_actual  <= '0;
                        err_count    <= '0;
                        pass         <= 1'b0;
                        done         <= 1'b0;
                    end
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (wcnt < SETTLE_C) begin
                        wcnt <= wcnt + 4'd1;
                    end else begin
                        err_count <= err_nxt;
                        if (mismatch && !first_fail) begin
                            first_fail   <= 1'b1;
                            fail_pattern <= pat[NIN-1:0];
                            fail_actual  <= dut_out;
                        end
                        wcnt <= '0;
                        pat  <= pat_nxt;
                        if (pat_nxt[NIN]) begin
                            // Last pattern compared; dut_in keeps its final value.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == 8'd0);
                        end else begin
                            dut_in <= pat_nxt[NIN-1:0];
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_exhaustive_checker.sv
// Directed bench for cell_exhaustive_checker: an inverter checker (NIN=1,
// SETTLE=1), a NAND2 checker (NIN=2, SETTLE=0) and an 8-input checker whose
// cell always mismatches, all on a shared clock and reset.
module tb_cell_exhaustive_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Inverter checker
    logic       inv_start, inv_mode;
    logic [0:0] inv_in, inv_out, inv_fa;
    logic [0:0] inv_fp;
    logic       inv_busy, inv_done, inv_pass;
    logic [7:0] inv_err;
    assign inv_out = inv_mode ? 1'b1 : ~inv_in;

    // NAND2 checker (mode 1 models a cell that behaves as AND)
    logic       nand_start, nand_mode;
    logic [1:0] nand_in, nand_fp;
    logic [0:0] nand_out, nand_fa;
    logic       nand_busy, nand_done, nand_pass;
    logic [7:0] nand_err;
    assign nand_out = nand_mode ? (&nand_in) : ~(&nand_in);

    // 8-input checker, cell output stuck at 1 against an all-zero table
    logic       sat_start;
    logic [7:0] sat_in, sat_fp;
    logic [0:0] sat_out, sat_fa;
    logic       sat_busy, sat_done, sat_pass;
    logic [7:0] sat_err;
    assign sat_out = 1'b1;

    cell_exhaustive_checker #(.NIN(1), .NOUT(1), .TRUTH(2'b01), .SETTLE(1)) u_inv (
        .clk(clk), .reset_n(reset_n), .start(inv_start), .dut_in(inv_in), .dut_out(inv_out),
        .busy(inv_busy), .done(inv_done), .pass(inv_pass), .fail_pattern(inv_fp),
        .fail_actual(inv_fa), .err_count(inv_err));

    cell_exhaustive_checker #(.NIN(2), .NOUT(1), .TRUTH(4'b0111), .SETTLE(0)) u_nand (
        .clk(clk), .reset_n(reset_n), .start(nand_start), .dut_in(nand_in), .dut_out(nand_out),
        .busy(nand_busy), .done(nand_done), .pass(nand_pass), .fail_pattern(nand_fp),
        .fail_actual(nand_fa), .err_count(nand_err));

    cell_exhaustive_checker #(.NIN(8), .NOUT(1), .TRUTH(256'd0), .SETTLE(0)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(sat_start), .dut_in(sat_in), .dut_out(sat_out),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .fail_pattern(sat_fp),
        .fail_actual(sat_fa), .err_count(sat_err));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_cmp++; if (inv_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", inv_busy); end
        n_cmp++; if (inv_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", inv_done); end
        n_cmp++; if (inv_pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %b want 0", inv_pass); end
        n_cmp++; if (inv_in !== 1'b0) begin n_bad++; $display("FAIL reset_dut_in got %b want 0", inv_in); end
        n_cmp++; if (sat_err !== 8'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", sat_err); end
        n_cmp++; if (nand_fp !== 2'd0 || nand_fa !== 1'b0) begin n_bad++; $display("FAIL reset_fail_regs got %0d/%b want 0/0", nand_fp, nand_fa); end
        #2 reset_n = 1'b1;
        step();
    endtask

    task automatic test_inverter_good();
        logic exp_seq [4];
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b1};
        inv_mode  = 1'b0;
        inv_start = 1'b1;
        step();
        inv_start = 1'b0;
        n_cmp++; if (inv_busy !== 1'b1 || inv_done !== 1'b0) begin n_bad++; $display("FAIL inv_start_flags got busy=%b done=%b want 1/0", inv_busy, inv_done); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_cmp++; if (inv_in !== exp_seq[i]) begin n_bad++; $display("FAIL inv_seq[%0d] got %b want %b", i, inv_in, exp_seq[i]); end
            n_cmp++; if (inv_done !== 1'b0) begin n_bad++; $display("FAIL inv_early_done[%0d] got %b want 0", i, inv_done); end
        end
        step();
        n_cmp++; if (inv_done !== 1'b1 || inv_busy !== 1'b0) begin n_bad++; $display("FAIL inv_end_flags got done=%b busy=%b want 1/0", inv_done, inv_busy); end
        n_cmp++; if (inv_pass !== 1'b1) begin n_bad++; $display("FAIL inv_pass got %b want 1", inv_pass); end
        n_cmp++; if (inv_err !== 8'd0) begin n_bad++; $display("FAIL inv_err got %0d want 0", inv_err); end
        n_cmp++; if (inv_in !== 1'b1) begin n_bad++; $display("FAIL inv_hold_dut_in got %b want 1", inv_in); end
    endtask

    task automatic test_stuck_at_1();
        inv_mode  = 1'b1;
        inv_start = 1'b1;
        step();
        inv_start = 1'b0;
        repeat (3) step();
        n_cmp++; if (inv_done !== 1'b0) begin n_bad++; $display("FAIL sa1_early_done got %b want 0", inv_done); end
        step();
        n_cmp++; if (inv_done !== 1'b1) begin n_bad++; $display("FAIL sa1_done got %b want 1", inv_done); end
        n_cmp++; if (inv_pass !== 1'b0) begin n_bad++; $display("FAIL sa1_pass got %b want 0", inv_pass); end
        n_cmp++; if (inv_err !== 8'd1) begin n_bad++; $display("FAIL sa1_err got %0d want 1", inv_err); end
        n_cmp++; if (inv_fp !== 1'b1) begin n_bad++; $display("FAIL sa1_fail_pattern got %b want 1", inv_fp); end
        n_cmp++; if (inv_fa !== 1'b1) begin n_bad++; $display("FAIL sa1_fail_actual got %b want 1", inv_fa); end
        inv_mode = 1'b0;
    endtask

    task automatic test_nand2();
        nand_mode  = 1'b0;
        nand_start = 1'b1;
        step();
        nand_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_cmp++; if (nand_in !== 2'(i) || nand_done !== 1'b0) begin n_bad++; $display("FAIL nand_seq[%0d] got in=%0d done=%b want %0d/0", i, nand_in, nand_done, i); end
        end
        step();
        n_cmp++; if (nand_done !== 1'b1 || nand_pass !== 1'b1 || nand_err !== 8'd0) begin n_bad++; $display("FAIL nand_good got done=%b pass=%b err=%0d want 1/1/0", nand_done, nand_pass, nand_err); end

        nand_mode  = 1'b1;
        nand_start = 1'b1;
        step();
        nand_start = 1'b0;
        repeat (4) step();
        n_cmp++; if (nand_done !== 1'b1 || nand_pass !== 1'b0) begin n_bad++; $display("FAIL and_flags got done=%b pass=%b want 1/0", nand_done, nand_pass); end
        n_cmp++; if (nand_err !== 8'd4) begin n_bad++; $display("FAIL and_err got %0d want 4", nand_err); end
        n_cmp++; if (nand_fp !== 2'd0 || nand_fa !== 1'b0) begin n_bad++; $display("FAIL and_first got pat=%0d act=%b want 0/0", nand_fp, nand_fa); end
    endtask

    task automatic test_saturation();
        sat_start = 1'b1;
        step();
        sat_start = 1'b0;
        repeat (255) step();
        n_cmp++; if (sat_done !== 1'b0 || sat_busy !== 1'b1) begin n_bad++; $display("FAIL sat_early got done=%b busy=%b want 0/1", sat_done, sat_busy); end
        step();
        n_cmp++; if (sat_done !== 1'b1) begin n_bad++; $display("FAIL sat_done got %b want 1", sat_done); end
        n_cmp++; if (sat_err !== 8'd255) begin n_bad++; $display("FAIL sat_err got %0d want 255", sat_err); end
        n_cmp++; if (sat_pass !== 1'b0 || sat_fp !== 8'd0 || sat_fa !== 1'b1) begin n_bad++; $display("FAIL sat_first got pass=%b pat=%0d act=%b want 0/0/1", sat_pass, sat_fp, sat_fa); end
    endtask

    task automatic test_reset_mid_run();
        inv_mode  = 1'b0;
        inv_start = 1'b1;
        step();
        inv_start = 1'b0;
        step();
        step();
        n_cmp++; if (inv_in !== 1'b1 || inv_busy !== 1'b1) begin n_bad++; $display("FAIL mid_pre got in=%b busy=%b want 1/1", inv_in, inv_busy); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (inv_busy !== 1'b0 || inv_in !== 1'b0 || inv_done !== 1'b0) begin n_bad++; $display("FAIL mid_async got busy=%b in=%b done=%b want 0/0/0", inv_busy, inv_in, inv_done); end
        n_cmp++; if (nand_err !== 8'd0 || nand_pass !== 1'b0) begin n_bad++; $display("FAIL mid_results got err=%0d pass=%b want 0/0", nand_err, nand_pass); end
        #2 reset_n = 1'b1;
        step();
        n_cmp++; if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin n_bad++; $display("FAIL mid_idle got busy=%b done=%b want 0/0", inv_busy, inv_done); end
        inv_start = 1'b1;
        step();
        inv_start = 1'b0;
        repeat (3) step();
        n_cmp++; if (inv_done !== 1'b0) begin n_bad++; $display("FAIL mid_rerun_early got %b want 0", inv_done); end
        step();
        n_cmp++; if (inv_done !== 1'b1 || inv_pass !== 1'b1 || inv_err !== 8'd0) begin n_bad++; $display("FAIL mid_rerun got done=%b pass=%b err=%0d want 1/1/0", inv_done, inv_pass, inv_err); end
    endtask

    task automatic test_start_while_busy();
        nand_mode  = 1'b1;
        nand_start = 1'b1;
        step();
        nand_start = 1'b0;
        step();
        nand_start = 1'b1;
        step();
        nand_start = 1'b0;
        n_cmp++; if (nand_in !== 2'd2 || nand_busy !== 1'b1) begin n_bad++; $display("FAIL busy_ignore got in=%0d busy=%b want 2/1", nand_in, nand_busy); end
        step();
        n_cmp++; if (nand_done !== 1'b0) begin n_bad++; $display("FAIL busy_len_early got %b want 0", nand_done); end
        step();
        n_cmp++; if (nand_done !== 1'b1 || nand_err !== 8'd4) begin n_bad++; $display("FAIL busy_len got done=%b err=%0d want 1/4", nand_done, nand_err); end

        nand_mode  = 1'b0;
        nand_start = 1'b1;
        step();
        nand_start = 1'b0;
        n_cmp++; if (nand_err !== 8'd0 || nand_done !== 1'b0) begin n_bad++; $display("FAIL restart_clear got err=%0d done=%b want 0/0", nand_err, nand_done); end
        n_cmp++; if (nand_busy !== 1'b1 || nand_in !== 2'd0) begin n_bad++; $display("FAIL restart_run got busy=%b in=%0d want 1/0", nand_busy, nand_in); end
        repeat (4) step();
        n_cmp++; if (nand_done !== 1'b1 || nand_pass !== 1'b1 || nand_err !== 8'd0) begin n_bad++; $display("FAIL restart_result got done=%b pass=%b err=%0d want 1/1/0", nand_done, nand_pass, nand_err); end
    endtask

    task automatic test_back_to_back();
        inv_mode  = 1'b0;
        inv_start = 1'b1;
        step();
        repeat (3) step();
        n_cmp++; if (inv_done !== 1'b0) begin n_bad++; $display("FAIL b2b_early got %b want 0", inv_done); end
        step();
        n_cmp++; if (inv_done !== 1'b1 || inv_pass !== 1'b1) begin n_bad++; $display("FAIL b2b_done got done=%b pass=%b want 1/1", inv_done, inv_pass); end
        step();
        inv_start = 1'b0;
        n_cmp++; if (inv_done !== 1'b0 || inv_busy !== 1'b1 || inv_in !== 1'b0) begin n_bad++; $display("FAIL b2b_restart got done=%b busy=%b in=%b want 0/1/0", inv_done, inv_busy, inv_in); end
        repeat (4) step();
        n_cmp++; if (inv_done !== 1'b1 || inv_err !== 8'd0) begin n_bad++; $display("FAIL b2b_second got done=%b err=%0d want 1/0", inv_done, inv_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        inv_start  = 1'b0;
        inv_mode   = 1'b0;
        nand_start = 1'b0;
        nand_mode  = 1'b0;
        sat_start  = 1'b0;
        test_reset();
        test_inverter_good();
        test_stuck_at_1();
        test_nand2();
        test_saturation();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
